sad_disparity_engine: RTL and testbench

//  Parametrised SAD block-matching stereo engine, successor to the fixed 7x7/64-disparity calculator.

---
 rtl/sad_disparity_engine.sv | 212 +++++++++++++++++++++
 tb/tb_sad_disparity_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_disparity_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sad_disparity_engine                                               |
// | SAD block-matching stereo engine; scores NUM_DISP windows per      |
// | pixel and packs RGB565 grey disparity lanes into FIFO words.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sad_disparity_engine #(
    parameter int HRES         = 640,
    parameter int VRES         = 480,
    parameter int ROWS_IN_BRAM = 8,
    parameter int WIN          = 7,
    parameter int NUM_DISP     = 64,
    parameter int PIX_W        = 12,
    parameter int BRAM_DATA_W  = 16,
    parameter int BRAM_ADDR_W  = 13,
    parameter int RD_LAT       = 2,
    parameter int FIFO_W       = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                go_i,
    input  logic                                busy_i,
    input  logic [PIX_W+$clog2(WIN*WIN)-1:0]    sad_thresh_i,
    output logic                                en_ref_o,
    output logic                                en_search_o,
    output logic [BRAM_ADDR_W-1:0]              addr_ref_o,
    output logic [BRAM_ADDR_W-1:0]              addr_search_o,
    input  logic [BRAM_DATA_W-1:0]              dout_ref_i,
    input  logic [BRAM_DATA_W-1:0]              dout_search_i,
    output logic [FIFO_W-1:0]                   fifo_din_o,
    output logic                                fifo_wr_en_o,
    input  logic                                fifo_full_i,
    output logic                                finished_row_o
);

    localparam int WH    = WIN / 2;
    localparam int SAD_W = PIX_W + $clog2(WIN * WIN);
    localparam int DW    = $clog2(NUM_DISP);
    localparam int TW    = $clog2(WIN);
    localparam int CW    = $clog2(HRES);
    localparam int RW    = $clog2(VRES);
    localparam int LANES = FIFO_W / 16;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]     COL_FIRST  = CW'(WH + NUM_DISP - 1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(HRES - 1 - WH);
    localparam logic [RW-1:0]     ROW_FIRST  = RW'(WH);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(VRES - 1 - WH);
    localparam logic [RD_LAT-1:0] NOT_OLDEST = {RD_LAT{1'b1}} >> 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DECIDE, S_WRITE} state_t;
    state_t state_q, state_d;

    logic [RW-1:0]              row_q;
    logic [CW-1:0]              col_q;
    logic [DW-1:0]              d_q;
    logic [TW-1:0]              wr_q, wc_q;
    logic [LW-1:0]              lane_q;
    logic [FIFO_W-1:0]          word_q;
    logic                       finished_q;
    logic [RD_LAT-1:0]          vld_q, first_q, last_q;
    logic [RD_LAT-1:0][DW-1:0]  dtag_q;
    logic [SAD_W-1:0]           sum_q, best_q;
    logic [DW-1:0]              bestd_q;

    logic                       w_issue, w_write, w_first_tap, w_last_tap, w_issue_done;
    logic                       w_lane_full, w_col_end, w_invalid, w_unused_hi;
    logic [BRAM_ADDR_W-1:0]     w_rb, w_ref_addr, w_srch_addr;
    logic [PIX_W-1:0]           w_a, w_b, w_absd;
    logic [SAD_W-1:0]           w_sum;
    logic [5:0]                 w_g6;
    logic [15:0]                w_lane_val;

    assign w_first_tap  = (wr_q == '0) && (wc_q == '0);
    assign w_last_tap   = (wr_q == TW'(WIN - 1)) && (wc_q == TW'(WIN - 1));
    assign w_issue_done = w_last_tap && (d_q == DW'(NUM_DISP - 1));
    assign w_lane_full  = (lane_q == LW'(LANES - 1));
    assign w_col_end    = (col_q == COL_LAST);

    always_comb begin
        state_d = state_q;
        w_issue = 1'b0;
        w_write = 1'b0;
        case (state_q)
            S_IDLE:   if (go_i) state_d = S_ISSUE;
            S_ISSUE:  if (!busy_i) begin
                          w_issue = 1'b1;
                          if (w_issue_done) state_d = S_DRAIN;
                      end
            // Only the oldest pipeline slot may still be live on the exit cycle.
            S_DRAIN:  if ((vld_q & NOT_OLDEST) == '0) state_d = S_DECIDE;
            S_DECIDE: state_d = (w_lane_full || w_col_end) ? S_WRITE : S_ISSUE;
            S_WRITE:  if (!fifo_full_i) begin
                          w_write = 1'b1;
                          state_d = w_col_end ? S_IDLE : S_ISSUE;
                      end
            default:  state_d = S_IDLE;
        endcase
        if (reset) begin
            w_issue = 1'b0;
            w_write = 1'b0;
        end
    end

    assign w_rb = ((BRAM_ADDR_W'(row_q) - BRAM_ADDR_W'(WH) + BRAM_ADDR_W'(wr_q))
                   % BRAM_ADDR_W'(ROWS_IN_BRAM)) * BRAM_ADDR_W'(HRES);
    assign w_ref_addr  = w_rb + BRAM_ADDR_W'(col_q) - BRAM_ADDR_W'(WH) + BRAM_ADDR_W'(wc_q);
    assign w_srch_addr = w_ref_addr - BRAM_ADDR_W'(d_q);

    assign en_ref_o       = w_issue;
    assign en_search_o    = w_issue;
    assign addr_ref_o     = w_issue ? w_ref_addr  : '0;
    assign addr_search_o  = w_issue ? w_srch_addr : '0;
    assign fifo_din_o     = word_q;
    assign fifo_wr_en_o   = w_write;
    assign finished_row_o = finished_q;

    assign w_a         = dout_ref_i[PIX_W-1:0];
    assign w_b         = dout_search_i[PIX_W-1:0];
    assign w_unused_hi = ^{dout_ref_i[BRAM_DATA_W-1:PIX_W], dout_search_i[BRAM_DATA_W-1:PIX_W]};
    assign w_absd      = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_sum       = (first_q[RD_LAT-1] ? '0 : sum_q) + SAD_W'(w_absd);

    assign w_invalid  = (best_q > sad_thresh_i);
    assign w_g6       = 6'(bestd_q) << (6 - DW);
    assign w_lane_val = w_invalid ? 16'h0000 : {w_g6[5:1], w_g6, w_g6[5:1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q      <= ROW_FIRST;
            col_q      <= COL_FIRST;
            d_q        <= '0;
            wr_q       <= '0;
            wc_q       <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            finished_q <= 1'b0;
            vld_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            dtag_q     <= '0;
            sum_q      <= '0;
            best_q     <= '1;
            bestd_q    <= '0;
        end else begin
            finished_q <= 1'b0;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                dtag_q[i]  <= dtag_q[i-1];
            end
            vld_q[0]   <= w_issue;
            first_q[0] <= w_first_tap;
            last_q[0]  <= w_last_tap;
            dtag_q[0]  <= d_q;

            if (w_issue) begin
                if (wc_q == TW'(WIN - 1)) begin
                    wc_q <= '0;
                    if (wr_q == TW'(WIN - 1)) begin
                        wr_q <= '0;
                        d_q  <= d_q + DW'(1);
                    end else begin
                        wr_q <= wr_q + TW'(1);
                    end
                end else begin
                    wc_q <= wc_q + TW'(1);
                end
            end

            if (vld_q[RD_LAT-1]) begin
                sum_q <= w_sum;
                if (last_q[RD_LAT-1] && (w_sum < best_q)) begin
                    best_q  <= w_sum;
                    bestd_q <= dtag_q[RD_LAT-1];
                end
            end

            if (state_q == S_DECIDE) begin
                for (int i = 0; i < LANES; i++) begin
                    if (lane_q == LW'(i)) word_q[i*16 +: 16] <= w_lane_val;
                end
                best_q  <= '1;
                bestd_q <= '0;
                if (!(w_lane_full || w_col_end)) begin
                    lane_q <= lane_q + LW'(1);
                    col_q  <= col_q + CW'(1);
                end
            end

            if (w_write) begin
                word_q <= '0;
                lane_q <= '0;
                if (w_col_end) begin
                    finished_q <= 1'b1;
                    col_q      <= COL_FIRST;
                    row_q      <= (row_q == ROW_LAST) ? ROW_FIRST : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_disparity_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sad_disparity_engine                                            |
// | Self-checking bench: BRAM model, scoreboard of expected FIFO words.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sad_disparity_engine;

    localparam int NPIX = 11;       // columns 4..14 for HRES=16, WIN=3, NUM_DISP=4
    localparam int COL0 = 4;
    localparam int ROW_CYC = NPIX * (4 * 9 + 2 + 1) + 6;

    logic        clk = 1'b0;
    logic        reset, go, busy, full;
    logic [11:0] thresh;
    logic        en_ref, en_search, wr_en, finished;
    logic [12:0] addr_ref, addr_search;
    logic [15:0] dout_ref, dout_search;
    logic [31:0] fifo_din;

    logic [15:0] ref_mem  [0:127];
    logic [15:0] srch_mem [0:127];
    logic [15:0] rp1, rp2, sp1, sp2;

    int tests = 0, fails = 0, en_cnt = 0, fin_cnt = 0, rows_done = 0, bench_row = 1, cyc = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          kind;      // 0 shifted texture, 1 uniform, 2 noise
        logic [11:0] th;
        bit          use_model;
        logic [31:0] word;
        logic [31:0] last;
        int          cycles;
    } vec_t;
    vec_t vecs[5];

    sad_disparity_engine #(
        .HRES(16), .VRES(8), .ROWS_IN_BRAM(8), .WIN(3), .NUM_DISP(4), .PIX_W(8),
        .BRAM_DATA_W(16), .BRAM_ADDR_W(13), .RD_LAT(2), .FIFO_W(32)
    ) dut (
        .clk(clk), .reset(reset), .go_i(go), .busy_i(busy), .sad_thresh_i(thresh),
        .en_ref_o(en_ref), .en_search_o(en_search),
        .addr_ref_o(addr_ref), .addr_search_o(addr_search),
        .dout_ref_i(dout_ref), .dout_search_i(dout_search),
        .fifo_din_o(fifo_din), .fifo_wr_en_o(wr_en), .fifo_full_i(full),
        .finished_row_o(finished)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency BRAMs
    always @(posedge clk) begin
        rp1 <= en_ref    ? ref_mem[addr_ref[6:0]]     : 16'h0;
        sp1 <= en_search ? srch_mem[addr_search[6:0]] : 16'h0;
        rp2 <= rp1;
        sp2 <= sp1;
    end
    assign dout_ref    = rp2;
    assign dout_search = sp2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        logic [15:0] r;
        for (int a = 0; a < 128; a++) begin
            r = 16'($urandom);
            ref_mem[a] = (kind == 1) ? {r[15:8], 8'd100} : r;
        end
        for (int a = 0; a < 128; a++) begin
            r = 16'($urandom);
            if (kind == 0 && a + 2 < 128) srch_mem[a] = {r[15:8], ref_mem[a+2][7:0]};
            else if (kind == 1)           srch_mem[a] = {r[15:8], 8'd100};
            else                          srch_mem[a] = r;
        end
    endtask

    function automatic logic [15:0] model_lane(input int row, input int col, input logic [11:0] th);
        int best = 4095;
        int bd = 0;
        int s, rb, x, y;
        logic [5:0] g6;
        for (int d = 0; d < 4; d++) begin
            s = 0;
            for (int wr = 0; wr < 3; wr++) begin
                rb = ((row - 1 + wr) % 8) * 16;
                for (int wc = 0; wc < 3; wc++) begin
                    x = int'(ref_mem[rb + col - 1 + wc][7:0]);
                    y = int'(srch_mem[rb + col - d - 1 + wc][7:0]);
                    s += (x > y) ? x - y : y - x;
                end
            end
            if (s < best) begin
                best = s;
                bd   = d;
            end
        end
        if (best > int'(th)) return 16'h0000;
        g6 = 6'(bd << 4);
        return {g6[5:1], g6, g6[5:1]};
    endfunction

    task automatic push_expected(input vec_t v);
        logic [31:0] w;
        w = '0;
        if (v.use_model) begin
            for (int p = 0; p < NPIX; p++) begin
                w[16*(p%2) +: 16] = model_lane(bench_row, COL0 + p, v.th);
                if (p % 2 == 1 || p == NPIX - 1) begin
                    exp_q.push_back(w);
                    w = '0;
                end
            end
        end else begin
            for (int k = 0; k < NPIX / 2; k++) exp_q.push_back(v.word);
            exp_q.push_back(v.last);
        end
    endtask

    task automatic run_row(output int cycles);
        en_cnt = 0;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        cycles = 0;
        while (!finished && cycles < 2000) begin
            @(posedge clk); #1 cycles++;
        end
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL row_timeout: got no finished_row after %0d cycles, expected %0d", cycles, ROW_CYC);
        end else begin
            @(posedge clk); #1;
            check("finished_pulse_width", 32'(finished), 32'd0);
            check("words_left_in_queue", 32'(exp_q.size()), 32'd0);
            check("enables_per_row", 32'(en_cnt), 32'd396);
            rows_done++;
            bench_row = (bench_row == 6) ? 1 : bench_row + 1;
        end
    endtask

    always @(negedge clk) begin
        int ea;
        if (!reset) begin
            if (en_ref || en_search) begin
                ea = ((bench_row - 1) % 8) * 16 + 3;
                check("en_pair", {30'd0, en_ref, en_search}, 32'd3);
                check("en_while_busy", 32'(busy), 32'd0);
                if (en_cnt == 0) begin
                    check("first_addr_ref", 32'(addr_ref), 32'(ea));
                    check("first_addr_search", 32'(addr_search), 32'(ea));
                end
                if (en_cnt == 9) begin
                    check("d1_addr_ref", 32'(addr_ref), 32'(ea));
                    check("d1_addr_search", 32'(addr_search), 32'(ea - 1));
                end
                en_cnt++;
            end
            if (wr_en) begin
                check("wr_while_full", 32'(full), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got word 0x%08h, expected no write", fifo_din);
                end else begin
                    check("fifo_word", fifo_din, exp_q.pop_front());
                end
            end
            if (finished) fin_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; go = 1'b0; busy = 1'b0; full = 1'b0; thresh = 12'hFFF;
        fill(0);
        vecs[0] = '{0, 12'hFFF, 1'b0, 32'h84108410, 32'h00008410, ROW_CYC};
        vecs[1] = '{1, 12'hFFF, 1'b0, 32'h00000000, 32'h00000000, ROW_CYC};
        vecs[2] = '{2, 12'h000, 1'b0, 32'h00000000, 32'h00000000, ROW_CYC};
        vecs[3] = '{2, 12'hFFF, 1'b1, 32'h00000000, 32'h00000000, ROW_CYC};
        vecs[4] = '{0, 12'd100, 1'b0, 32'h84108410, 32'h00008410, ROW_CYC};

        repeat (3) @(posedge clk);
        #1;
        check("rst_en_ref", 32'(en_ref), 32'd0);
        check("rst_en_search", 32'(en_search), 32'd0);
        check("rst_addr_ref", 32'(addr_ref), 32'd0);
        check("rst_addr_search", 32'(addr_search), 32'd0);
        check("rst_fifo_din", fifo_din, 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_finished", 32'(finished), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            fill(vecs[i].kind);
            thresh = vecs[i].th;
            push_expected(vecs[i]);
            run_row(cyc);
            check("row_cycles", 32'(cyc), 32'(vecs[i].cycles));
        end

        // busy for 5 cycles inside the first pixel's ISSUE phase
        fill(0);
        thresh = 12'hFFF;
        push_expected(vecs[0]);
        fork
            run_row(cyc);
            begin
                repeat (21) @(posedge clk);
                #1 busy = 1'b1;
                repeat (5) @(posedge clk);
                #1 busy = 1'b0;
            end
        join
        check("busy_row_cycles", 32'(cyc), 32'(ROW_CYC + 5));

        // FIFO full across the first WRITE (cycles 79..88)
        push_expected(vecs[0]);
        full = 1'b1;
        fork
            run_row(cyc);
            begin
                repeat (81) @(posedge clk);
                #1 check("stalled_word_early", fifo_din, 32'h84108410);
                repeat (8) @(posedge clk);
                #1 check("stalled_word_late", fifo_din, 32'h84108410);
                check("no_wr_while_full", 32'(wr_en), 32'd0);
                full = 1'b0;
            end
        join
        check("full_row_cycles", 32'(cyc), 32'(ROW_CYC + 10));

        // reset in the middle of ISSUE: no write, DUT back to IDLE at the first row
        en_cnt = 0;
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_en_ref", 32'(en_ref), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_fifo_din", fifo_din, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        bench_row = 1;
        repeat (20) @(posedge clk);
        #1 check("idle_after_reset_en", 32'(en_ref), 32'd0);

        fill(0);
        push_expected(vecs[0]);
        run_row(cyc);
        check("post_reset_row_cycles", 32'(cyc), 32'(ROW_CYC));
        check("finished_pulses", 32'(fin_cnt), 32'(rows_done));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
